// File: rtl/bp_table_port_scheduler.sv
// bp_table_port_scheduler
//   Arbitrates the single BTB/pattern-counter table port between fetch-side
//   lookups and commit-side updates. Updates are buffered in a small FIFO;
//   fetch wins by default, but a starvation guard and a full-queue override
//   force the head update through so the queue always drains.
//   Optional statistics counters are compiled in with `define BPS_STATS_EN.
module bp_table_port_scheduler #(
    parameter int PC_W       = 5,
    parameter int IDX_W      = 2,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    lk_req,
    input  logic [PC_W-1:0]         lk_pc,
    output logic                    lk_gnt,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic [PC_W-1:0]         up_pc,
    input  logic                    up_taken,
    input  logic [PC_W-1:0]         up_target,
    output logic                    tbl_en,
    output logic                    tbl_we,
    output logic [IDX_W-1:0]        tbl_idx,
    output logic [PC_W-IDX_W-1:0]   tbl_tag,
    output logic                    tbl_taken,
    output logic [PC_W-1:0]         tbl_target,
    output logic [$clog2(QDEPTH):0] q_count
`ifdef BPS_STATS_EN
    ,
    output logic [7:0]              stat_lookups,
    output logic [7:0]              stat_updates,
    output logic [7:0]              stat_forced
`endif
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam int PW    = $clog2(QDEPTH);
    localparam int SW    = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(QDEPTH);
    localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_UPDATE
    } state_t;

    state_t state_q, state_d;

    logic [PC_W-1:0] fifo_pc     [QDEPTH];
    logic            fifo_taken  [QDEPTH];
    logic [PC_W-1:0] fifo_target [QDEPTH];

    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [SW-1:0]   starve;

    logic            full;
    logic            pending;
    logic            force_upd;
    logic            push;
    logic            pop;

    // Grant decision; up_ready looks only at the registered count, so a pop
    // in the full cycle does not reopen the queue until the next cycle.
    always_comb begin
        full      = (q_count == FULL_CNT);
        pending   = (q_count != '0);
        force_upd = pending && (full || (starve == STARVE_LIM));
        up_ready  = !full;
        push      = up_valid && !full;
        lk_gnt    = lk_req && !force_upd;
        pop       = pending && !lk_gnt;
    end

    // FIFO storage: written at the tail on push, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]     <= up_pc;
            fifo_taken[wr_ptr]  <= up_taken;
            fifo_target[wr_ptr] <= up_target;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at QDEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   q_count <= q_count + CNT_W'(1);
                2'b01:   q_count <= q_count - CNT_W'(1);
                default: q_count <= q_count;
            endcase
        end
    end

    // Starvation counter: counts lookup wins over a waiting update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve <= '0;
        end else if (pop || !pending) begin
            starve <= '0;
        end else if (lk_gnt && starve != STARVE_LIM) begin
            starve <= starve + SW'(1);
        end
    end

    // FSM state register: remembers which requester was issued last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state follows this cycle's winner.
    always_comb begin
        state_d = ST_IDLE;
        if (lk_gnt)   state_d = ST_LOOKUP;
        else if (pop) state_d = ST_UPDATE;
    end

    assign tbl_en = (state_q != ST_IDLE);
    assign tbl_we = (state_q == ST_UPDATE);

    // Table command fields: loaded from the winner, held when nobody wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_idx    <= '0;
            tbl_tag    <= '0;
            tbl_taken  <= 1'b0;
            tbl_target <= '0;
        end else if (lk_gnt) begin
            tbl_idx    <= lk_pc[IDX_W-1:0];
            tbl_tag    <= lk_pc[PC_W-1:IDX_W];
            tbl_taken  <= 1'b0;
            tbl_target <= '0;
        end else if (pop) begin
            tbl_idx    <= fifo_pc[rd_ptr][IDX_W-1:0];
            tbl_tag    <= fifo_pc[rd_ptr][PC_W-1:IDX_W];
            tbl_taken  <= fifo_taken[rd_ptr];
            tbl_target <= fifo_target[rd_ptr];
        end
    end

`ifdef BPS_STATS_EN
    // Saturating activity counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_updates <= '0;
            stat_forced  <= '0;
        end else begin
            if (lk_gnt && stat_lookups != 8'hFF)
                stat_lookups <= stat_lookups + 8'd1;
            if (pop && stat_updates != 8'hFF)
                stat_updates <= stat_updates + 8'd1;
            if (lk_req && force_upd && stat_forced != 8'hFF)
                stat_forced <= stat_forced + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bp_table_port_scheduler.sv
// tb_bp_table_port_scheduler
//   Directed stimulus with hand-computed expectations. Each issued table
//   command is pushed into a scoreboard queue; a monitor compares it when
//   the DUT raises tbl_en one cycle later.
module tb_bp_table_port_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lk_req = 1'b0;
    logic [4:0] lk_pc = '0;
    logic       lk_gnt;
    logic       up_valid = 1'b0;
    logic       up_ready;
    logic [4:0] up_pc = '0;
    logic       up_taken = 1'b0;
    logic [4:0] up_target = '0;
    logic       tbl_en;
    logic       tbl_we;
    logic [1:0] tbl_idx;
    logic [2:0] tbl_tag;
    logic       tbl_taken;
    logic [4:0] tbl_target;
    logic [2:0] q_count;
`ifdef BPS_STATS_EN
    logic [7:0] stat_lookups, stat_updates, stat_forced;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // {we, idx, tag, taken, target}
    logic [11:0] sb[$];
    logic [11:0] mon_got, mon_exp;

    bp_table_port_scheduler #(
        .PC_W(5), .IDX_W(2), .QDEPTH(4), .STARVE_MAX(3)
    ) dut (
        .clk(clk), .rst(rst),
        .lk_req(lk_req), .lk_pc(lk_pc), .lk_gnt(lk_gnt),
        .up_valid(up_valid), .up_ready(up_ready), .up_pc(up_pc),
        .up_taken(up_taken), .up_target(up_target),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_tag(tbl_tag),
        .tbl_taken(tbl_taken), .tbl_target(tbl_target), .q_count(q_count)
`ifdef BPS_STATS_EN
        , .stat_lookups(stat_lookups), .stat_updates(stat_updates),
        .stat_forced(stat_forced)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h required=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic expect_cmd(input logic we, input logic [1:0] idx, input logic [2:0] tag,
                              input logic tk, input logic [4:0] tgt);
        sb.push_back({we, idx, tag, tk, tgt});
    endtask

    // One clock cycle of stimulus plus checks of the combinational outputs.
    task automatic step(input logic lr, input logic [4:0] lpc,
                        input logic uv, input logic [4:0] upc, input logic ut,
                        input logic [4:0] utg,
                        input logic eg, input logic er, input logic [2:0] eq);
        @(posedge clk);
        #1;
        lk_req = lr; lk_pc = lpc;
        up_valid = uv; up_pc = upc; up_taken = ut; up_target = utg;
        #3;
        chk("lk_gnt", 12'(lk_gnt), 12'(eg));
        chk("up_ready", 12'(up_ready), 12'(er));
        chk("q_count", 12'(q_count), 12'(eq));
    endtask

    task automatic idle(input logic [2:0] eq);
        step(1'b0, 5'b0, 1'b0, 5'b0, 1'b0, 5'b0, 1'b0, 1'b1, eq);
    endtask

    // Scoreboard monitor: every table access must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && tbl_en) begin
            mon_got = {tbl_we, tbl_idx, tbl_tag, tbl_taken, tbl_target};
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_tbl_cmd got=%h required=none at %0t", mon_got, $time);
            end else begin
                mon_exp = sb.pop_front();
                chk("tbl_cmd", mon_got, mon_exp);
            end
        end
    end

    initial begin
        // Reset, idle
        #3;
        chk("rst_tbl_en", 12'(tbl_en), 12'd0);
        chk("rst_q_count", 12'(q_count), 12'd0);
        chk("rst_up_ready", 12'(up_ready), 12'd1);
        chk("rst_lk_gnt", 12'(lk_gnt), 12'd0);
        @(posedge clk); #1 rst = 1'b0;
        idle(3'd0);

        // Lookup only
        step(1'b1, 5'b01101, 1'b0, 5'b0, 1'b0, 5'b0, 1'b1, 1'b1, 3'd0);
        expect_cmd(1'b0, 2'b01, 3'b011, 1'b0, 5'b00000);
        idle(3'd0);

        // Update only: pushed in cycle 0, issued in cycle 1, visible in cycle 2
        step(1'b0, 5'b0, 1'b1, 5'b01001, 1'b1, 5'b10010, 1'b0, 1'b1, 3'd0);
        idle(3'd1);
        expect_cmd(1'b1, 2'b01, 3'b010, 1'b1, 5'b10010);
        idle(3'd0);

        // Starvation: three lookups win, then the update is forced
        step(1'b0, 5'b0, 1'b1, 5'b10110, 1'b0, 5'b00111, 1'b0, 1'b1, 3'd0);
        step(1'b1, 5'b00001, 1'b0, 5'b0, 1'b0, 5'b0, 1'b1, 1'b1, 3'd1);
        expect_cmd(1'b0, 2'b01, 3'b000, 1'b0, 5'b0);
        step(1'b1, 5'b00010, 1'b0, 5'b0, 1'b0, 5'b0, 1'b1, 1'b1, 3'd1);
        expect_cmd(1'b0, 2'b10, 3'b000, 1'b0, 5'b0);
        step(1'b1, 5'b00011, 1'b0, 5'b0, 1'b0, 5'b0, 1'b1, 1'b1, 3'd1);
        expect_cmd(1'b0, 2'b11, 3'b000, 1'b0, 5'b0);
        step(1'b1, 5'b00100, 1'b0, 5'b0, 1'b0, 5'b0, 1'b0, 1'b1, 3'd1);
        expect_cmd(1'b1, 2'b10, 3'b101, 1'b0, 5'b00111);
        step(1'b1, 5'b00101, 1'b0, 5'b0, 1'b0, 5'b0, 1'b1, 1'b1, 3'd0);
        expect_cmd(1'b0, 2'b01, 3'b001, 1'b0, 5'b0);
        idle(3'd0);

        // Full override: fill four, push while full is dropped, drain in order
        step(1'b1, 5'b11111, 1'b1, 5'b00001, 1'b1, 5'b00010, 1'b1, 1'b1, 3'd0);
        expect_cmd(1'b0, 2'b11, 3'b111, 1'b0, 5'b0);
        step(1'b1, 5'b11110, 1'b1, 5'b00110, 1'b0, 5'b01000, 1'b1, 1'b1, 3'd1);
        expect_cmd(1'b0, 2'b10, 3'b111, 1'b0, 5'b0);
        step(1'b1, 5'b11101, 1'b1, 5'b01011, 1'b1, 5'b10100, 1'b1, 1'b1, 3'd2);
        expect_cmd(1'b0, 2'b01, 3'b111, 1'b0, 5'b0);
        step(1'b1, 5'b11100, 1'b1, 5'b11100, 1'b0, 5'b00011, 1'b1, 1'b1, 3'd3);
        expect_cmd(1'b0, 2'b00, 3'b111, 1'b0, 5'b0);
        step(1'b1, 5'b11011, 1'b1, 5'b10101, 1'b1, 5'b11111, 1'b0, 1'b0, 3'd4);
        expect_cmd(1'b1, 2'b01, 3'b000, 1'b1, 5'b00010);
        step(1'b1, 5'b01010, 1'b0, 5'b0, 1'b0, 5'b0, 1'b1, 1'b1, 3'd3);
        expect_cmd(1'b0, 2'b10, 3'b010, 1'b0, 5'b0);
        idle(3'd3);
        expect_cmd(1'b1, 2'b10, 3'b001, 1'b0, 5'b01000);
        idle(3'd2);
        expect_cmd(1'b1, 2'b11, 3'b010, 1'b1, 5'b10100);
        idle(3'd1);
        expect_cmd(1'b1, 2'b00, 3'b111, 1'b0, 5'b00011);
        idle(3'd0);
        idle(3'd0);

        // Async reset mid-drain with three updates queued
        step(1'b1, 5'b00000, 1'b1, 5'b00011, 1'b1, 5'b00001, 1'b1, 1'b1, 3'd0);
        expect_cmd(1'b0, 2'b00, 3'b000, 1'b0, 5'b0);
        step(1'b1, 5'b00000, 1'b1, 5'b00111, 1'b0, 5'b00010, 1'b1, 1'b1, 3'd1);
        expect_cmd(1'b0, 2'b00, 3'b000, 1'b0, 5'b0);
        // this lookup's output is cut short by the reset below
        step(1'b1, 5'b00000, 1'b1, 5'b01111, 1'b1, 5'b00100, 1'b1, 1'b1, 3'd2);
        @(posedge clk);
        #1;
        chk("pre_rst_q_count", 12'(q_count), 12'd3);
        chk("pre_rst_tbl_en", 12'(tbl_en), 12'd1);
        lk_req = 1'b0; up_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_q_count", 12'(q_count), 12'd0);
        chk("arst_tbl_en", 12'(tbl_en), 12'd0);
        chk("arst_tbl_fields", {tbl_we, tbl_idx, tbl_tag, tbl_taken, tbl_target}, 12'd0);
        chk("arst_up_ready", 12'(up_ready), 12'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3'd0);
        idle(3'd0);
        idle(3'd0);
        idle(3'd0);

        // Every expected command must have been observed
        chk("scoreboard_left", 12'(sb.size()), 12'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bp_table_port_scheduler.md
Name: bp_table_port_scheduler

Overview:
- Owns the single table port of the level-2 branch predictor's BTB/pattern-counter arrays.
- Shares that port between two requesters: fetch-side lookups and commit-side updates.
- Commit-side updates are resolved branches carrying PC, outcome and target. They are buffered in a small FIFO.
- Fetch has priority. A starvation guard and a full-queue override guarantee that updates drain.

Parameters:
- PC_W, 5, PC / target width
- IDX_W, 2, table index width (PC[IDX_W-1:0]); tag = PC[PC_W-1:IDX_W]
- QDEPTH, 4, update FIFO depth (power of 2, >=2)
- STARVE_MAX, 3, consecutive lookup wins allowed while the queue is non-empty

Ports:
- clk, in, 1, clock
- rst, in, 1, asynchronous active-high reset
- lk_req, in, 1, fetch lookup request
- lk_pc, in, PC_W, lookup PC
- lk_gnt, out, 1, lookup granted this cycle (combinational)
- up_valid, in, 1, resolved-branch update offered
- up_ready, out, 1, FIFO can accept an update (combinational, = !full)
- up_pc, in, PC_W, branch PC
- up_taken, in, 1, actual outcome
- up_target, in, PC_W, actual next PC (effective address)
- tbl_en, out, 1, table access valid (registered)
- tbl_we, out, 1, 1 = update write, 0 = lookup read (registered)
- tbl_idx, out, IDX_W, table index (registered)
- tbl_tag, out, PC_W-IDX_W, tag (registered)
- tbl_taken, out, 1, outcome for counter/history update (registered)
- tbl_target, out, PC_W, target for BTB write (registered)
- q_count, out, log2(QDEPTH)+1, FIFO occupancy (registered)

Behaviour:
- Reset (async, immediate):
  - FIFO emptied; q_count=0; starvation counter=0; FSM=IDLE.
  - All tbl_* outputs = 0.
  - Reset mid-operation discards all queued updates; nothing is replayed.
- Enqueue: up_valid && up_ready pushes {pc, taken, target} at the clock edge.
  - No bypass: an update pushed in cycle N issues no earlier than cycle N+1.
- Force condition: force = (q_count==QDEPTH) || (starve==STARVE_MAX). Only valid when q_count>0.
- Grant, combinational, in cycle N:
  - lk_gnt = lk_req && !(force && q_count>0).
  - Update issues = q_count>0 && !lk_gnt.
- Table command: the winner drives tbl_* at edge N+1. Latency exactly 1 cycle.
  - Lookup: tbl_we=0, idx/tag from lk_pc, tbl_taken=0, tbl_target=0.
  - Update: tbl_we=1, fields from FIFO head; head pops at the same edge.
  - No winner: tbl_en=0; other tbl_* hold.
- FSM (state = last issued): IDLE, LOOKUP, UPDATE. Transition each cycle to the winner's state, or to IDLE if no winner. Used for tbl_en/tbl_we decode.
- Starvation counter:
  - Increments when lk_gnt && q_count>0, saturating at STARVE_MAX.
  - Clears when an update issues or when q_count==0.
- Full queue:
  - up_ready=0.
  - A pop in the same cycle does not reopen the queue until the next cycle; up_ready depends only on registered q_count.
- Simultaneous push+pop: q_count unchanged, FIFO order preserved. Pointers wrap modulo QDEPTH.
- Ordering: updates issue strictly in arrival order.
- lk_req held while lk_gnt=0 is the requester's responsibility; the block keeps no lookup state.

Optional Feature:
- Macro: BPS_STATS_EN.
- Defined:
  - Adds outputs stat_lookups[7:0], stat_updates[7:0], stat_forced[7:0].
  - Each is a saturating count of issued lookups, issued updates, and cycles where force denied a pending lk_req.
  - All reset to 0.
- Undefined: these ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Reset, idle: rst pulse, no requests → tbl_en=0, q_count=0, up_ready=1, lk_gnt=0.
- Lookup only: lk_req=1, lk_pc=5'b01101 → lk_gnt=1 same cycle; next cycle tbl_en=1, tbl_we=0, tbl_idx=2'b01, tbl_tag=3'b011.
- Update only: push pc=5'b01001, taken=1, target=5'b10010 at cycle 0 → cycle 2 shows tbl_we=1, idx=01, tag=010, tbl_taken=1, tbl_target=10010; q_count back to 0.
- Starvation: one update queued, lk_req held high → exactly 3 lookups granted, then lk_gnt=0 for one cycle while the update issues, then lookups resume.
- Full override: push 4 updates with lk_req=1 → up_ready=0 at q_count=4; next cycle lk_gnt=0 and the head update issues. A push attempted while full is not accepted; FIFO order is verified on drain.
- Async reset mid-drain: assert rst between clock edges with q_count=3 → q_count=0 and tbl_en=0 immediately; no queued update appears after release.
